pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It merges three inputs into one consistent set of per-stage write-enable, bubble and flush controls:
- the load-use / branch-operand hazard flags from hazard detection,
- the branch/jump flush request,
- a variable-latency data-memory handshake.

It owns a FSM for multi-cycle memory waits, a timeout watchdog and a saturating stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 16, consecutive not-ready memory cycles before fatal error (legal range 2..255)
CNT_W, 16, width of stall_cycles counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
mem_req  in  1  MEM stage holds a valid load/store this cycle
mem_ready  in  1  data memory completes access this cycle
load_use_hazard  in  1  load-use dependency between EX and ID
branch_hazard  in  1  ID branch operands not yet forwardable
flush_req  in  1  taken branch or jump resolved in ID
pc_write  out  1  PC register enable
if_id_write  out  1  IF/ID register enable
id_ex_bubble  out  1  zero ID/EX control fields (insert nop)
ex_mem_write  out  1  EX/MEM register enable
mem_wb_bubble  out  1  zero MEM/WB control fields
if_id_flush  out  1  clear IF/ID instruction to nop
mem_error  out  1  sticky memory-timeout error
state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERROR
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Clock is `clock`. Reset is `reset_n`, asynchronous, active-low.
- While reset_n=0:
  - state=RUN, wait_cnt=0, stall_cycles=0, mem_error=0.
  - Outputs forced: pc_write=0, if_id_write=0, ex_mem_write=0, id_ex_bubble=1, mem_wb_bubble=1, if_id_flush=0.
- Control outputs are combinational from state and current inputs (zero latency). wait_cnt, state, mem_error and stall_cycles are registered.
- `miss` = mem_req & ~mem_ready.
- RUN, priority high to low:
  1. miss → freeze: pc_write=if_id_write=ex_mem_write=0, id_ex_bubble=0 (ID/EX holds), mem_wb_bubble=1, if_id_flush=0. Set wait_cnt=1 and go to MEM_WAIT.
  2. load_use_hazard | branch_hazard → pc_write=if_id_write=0, id_ex_bubble=1, ex_mem_write=1, mem_wb_bubble=0, if_id_flush=0. Stay in RUN.
  3. Otherwise all enables 1, bubbles 0, if_id_flush=flush_req.
- Flush is suppressed whenever any stall is active. ID is held, so flush_req re-presents itself once the stall clears.
- MEM_WAIT:
  - miss → same freeze outputs as RUN case 1. wait_cnt increments; on the edge where wait_cnt would reach MEM_TIMEOUT, go to ERROR instead.
  - ~miss (mem_ready=1, or mem_req dropped) → access completes. Outputs evaluated exactly as RUN cases 2/3 (ex_mem_write=1, mem_wb_bubble=0). Clear wait_cnt and go to RUN.
- ERROR: all enables 0, bubbles 1, flush 0, mem_error=1. Only reset exits.
- Error timing: not-ready cycles are numbered from 1, counting the RUN cycle where the miss was first seen. ERROR is entered after the edge ending not-ready cycle number MEM_TIMEOUT.
- stall_cycles: increments on each rising edge where pc_write=0 and state≠ERROR. Saturates at all-ones, no wrap.
- A reset asserted mid-wait aborts immediately to reset values. No pending state survives.

Test Plan:
- Reset → all control outputs at their forced reset values. Release reset with all inputs 0 → pc_write=1, all bubbles 0, state_o=0, stall_cycles=0.
- load_use_hazard=1 for 1 cycle → that cycle pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_write=1; next cycle normal; stall_cycles=1.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 → 3 frozen cycles with state_o 0,1,1 and mem_wb_bubble=1. Completion cycle has ex_mem_write=1, state_o=1; then RUN. stall_cycles=3.
- flush_req=1 with branch_hazard=1 → if_id_flush=0 and stall. Next cycle with branch_hazard=0 → if_id_flush=1, pc_write=1.
- Miss and load_use in the same cycle → memory freeze wins (id_ex_bubble=0, ex_mem_write=0).
- MEM_TIMEOUT=4, mem_ready held 0 → ERROR (state_o=2, mem_error=1) from not-ready cycle 5 onward. stall_cycles frozen at 4. Asserting reset_n=0 clears everything asynchronously.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Merges hazard flags, the branch/jump flush request and a variable-latency
// data-memory handshake into per-stage enable, bubble and flush controls.
// Control outputs are combinational from the current state and inputs; the
// wait counter, state, sticky error and stall-cycle counter are registered.
module pipe_stall_ctrl #(
   parameter int MEM_TIMEOUT = 16,  // consecutive not-ready cycles before error (2..255)
   parameter int CNT_W       = 16   // width of the stall-cycle counter
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             load_use_hazard,
   input  logic             branch_hazard,
   input  logic             flush_req,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_bubble,
   output logic             ex_mem_write,
   output logic             mem_wb_bubble,
   output logic             if_id_flush,
   output logic             mem_error,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   // The RUN cycle that first sees the miss counts as not-ready cycle 1, so the
   // error edge is the one where the counter already holds MEM_TIMEOUT-1.
   localparam logic [7:0]       LAST_WAIT = 8'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t     state;
   logic [7:0] wait_cnt;
   logic       miss;
   logic       hazard;

   assign miss    = mem_req & ~mem_ready;
   assign hazard  = load_use_hazard | branch_hazard;
   assign state_o = state;

   // Per-stage controls: memory freeze beats hazard stall beats normal flow;
   // reset and ERROR both park the pipe with every enable off.
   always_comb begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_bubble  = 1'b1;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
      if_id_flush   = 1'b0;
      if (reset_n && (state == RUN || state == MEM_WAIT)) begin
         if (miss) begin
            // Whole front end frozen; ID/EX holds its contents rather than bubbling.
            id_ex_bubble  = 1'b0;
         end else if (hazard) begin
            // Hold PC and IF/ID, let older instructions drain, inject a nop into EX.
            ex_mem_write  = 1'b1;
            mem_wb_bubble = 1'b0;
         end else begin
            // Flush only when nothing stalls; a held ID re-presents flush_req later.
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            id_ex_bubble  = 1'b0;
            ex_mem_write  = 1'b1;
            mem_wb_bubble = 1'b0;
            if_id_flush   = flush_req;
         end
      end
   end

   // Memory-wait FSM with timeout watchdog, sticky error and saturating stall counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= RUN;
         wait_cnt     <= 8'd0;
         mem_error    <= 1'b0;
         stall_cycles <= '0;
      end else begin
         unique case (state)
            RUN: begin
               if (miss) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= 8'd1;
               end
            end
            MEM_WAIT: begin
               if (miss) begin
                  if (wait_cnt == LAST_WAIT) begin
                     state     <= ERROR;
                     mem_error <= 1'b1;
                  end else begin
                     wait_cnt <= wait_cnt + 8'd1;
                  end
               end else begin
                  state    <= RUN;
                  wait_cnt <= 8'd0;
               end
            end
            ERROR: begin
               mem_error <= 1'b1;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= 8'd0;
            end
         endcase
         if (!pc_write && state != ERROR && stall_cycles != CNT_MAX)
            stall_cycles <= stall_cycles + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed steps from the test plan followed by
// randomized traffic, all checked against a behavioural model that tracks the
// number of consecutive not-ready memory cycles, a sticky error flag and the
// stall-cycle total as plain integers.
module tb_pipe_stall_ctrl;

   localparam int T    = 4;
   localparam int CW   = 6;
   localparam int CMAX = (1 << CW) - 1;

   // clock / reset
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   logic mem_req, mem_ready, load_use_hazard, branch_hazard, flush_req;
   logic pc_write, if_id_write, id_ex_bubble, ex_mem_write, mem_wb_bubble, if_id_flush;
   logic mem_error;
   logic [1:0] state_o;
   logic [CW-1:0] stall_cycles;

   pipe_stall_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
      .clock(clock), .reset_n(reset_n),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .load_use_hazard(load_use_hazard), .branch_hazard(branch_hazard),
      .flush_req(flush_req),
      .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
      .ex_mem_write(ex_mem_write), .mem_wb_bubble(mem_wb_bubble),
      .if_id_flush(if_id_flush), .mem_error(mem_error),
      .state_o(state_o), .stall_cycles(stall_cycles)
   );

   // reference model state
   int nr;    // consecutive not-ready cycles seen so far
   bit err;   // timeout reached
   int cnt;   // stall cycles, saturating

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected {pc, if_id, id_ex_bubble, ex_mem, mem_wb_bubble, flush}
   function automatic logic [5:0] exp_ctrl(input bit rst_active, input bit mr, input bit mrdy,
                                           input bit lu, input bit bh, input bit fr);
      if (rst_active || err)  return 6'b001010;
      if (mr && !mrdy)        return 6'b000010;
      if (lu || bh)           return 6'b001100;
      return {5'b11010, fr};
   endfunction

   function automatic logic [5:0] obs_ctrl();
      return {pc_write, if_id_write, id_ex_bubble, ex_mem_write, mem_wb_bubble, if_id_flush};
   endfunction

   task automatic model_clear();
      nr = 0; err = 0; cnt = 0;
   endtask

   task automatic check_all(input string tag, input logic [5:0] ev);
      chk({tag, ".ctrl"}, 32'(obs_ctrl()), 32'(ev));
      chk({tag, ".state"}, 32'(state_o), err ? 32'd2 : (nr > 0 ? 32'd1 : 32'd0));
      chk({tag, ".mem_error"}, 32'(mem_error), 32'(err));
      chk({tag, ".stall"}, 32'(stall_cycles), 32'(cnt));
   endtask

   // driver: one clock cycle, inputs applied after the falling edge
   task automatic step(input bit mr, input bit mrdy, input bit lu, input bit bh, input bit fr);
      logic [5:0] ev;
      mem_req = mr; mem_ready = mrdy; load_use_hazard = lu; branch_hazard = bh; flush_req = fr;
      #1;
      ev = exp_ctrl(1'b0, mr, mrdy, lu, bh, fr);
      check_all("step", ev);
      @(posedge clock);
      if (!err && !ev[5]) cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
      if (!err) begin
         if (mr && !mrdy) begin
            nr++;
            if (nr >= T) err = 1;
         end else begin
            nr = 0;
         end
      end
      @(negedge clock);
   endtask

   // asynchronous reset away from any clock edge, checked before any edge arrives
   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      model_clear();
      #1;
      check_all("reset", exp_ctrl(1'b1, mem_req, mem_ready, load_use_hazard, branch_hazard, flush_req));
      @(negedge clock);
      @(negedge clock);
      mem_req = 0; mem_ready = 0; load_use_hazard = 0; branch_hazard = 0; flush_req = 0;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      mem_req = 0; mem_ready = 0; load_use_hazard = 0; branch_hazard = 0; flush_req = 0;
      model_clear();
      #3;
      check_all("por", 6'b001010);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      // normal flow, then a single load-use stall
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("lu_stall_count", 32'(stall_cycles), 32'd1);

      // three-cycle memory miss then completion
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("mem_wait_state", 32'(state_o), 32'd1);
      step(1, 1, 0, 0, 0);
      chk("mem_done_state", 32'(state_o), 32'd0);
      chk("mem_stall_count", 32'(stall_cycles), 32'd4);

      // flush suppressed while stalled, honoured once the hazard clears
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1);

      // miss and load-use together: memory freeze wins
      step(1, 0, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0);

      // counter saturation
      do_reset();
      for (int i = 0; i < CMAX + 8; i++) step(0, 0, 1, 0, 0);
      chk("stall_saturated", 32'(stall_cycles), 32'(CMAX));

      // timeout into ERROR, then asynchronous reset out of it
      do_reset();
      for (int i = 0; i < T; i++) step(1, 0, 0, 0, 0);
      chk("err_state", 32'(state_o), 32'd2);
      chk("err_flag", 32'(mem_error), 32'd1);
      step(1, 0, 1, 0, 1);
      step(0, 0, 0, 0, 0);
      chk("err_stall_frozen", 32'(stall_cycles), 32'(T));
      do_reset();
      step(0, 0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         bit mr, mrdy, lu, bh, fr;
         mr   = ($urandom_range(0, 1) == 1);
         mrdy = ($urandom_range(0, 9) < ((i < 300) ? 6 : 2));
         lu   = ($urandom_range(0, 4) == 0);
         bh   = ($urandom_range(0, 4) == 0);
         fr   = ($urandom_range(0, 2) == 0);
         step(mr, mrdy, lu, bh, fr);
         if (err && $urandom_range(0, 3) == 0) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // overall time bound
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

endmodule
